// File: rtl/ms_board_pkg.sv
// rtl/ms_board_pkg.sv - shared command/state enums and cell-word bit positions
package ms_board_pkg;

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_FLAG     = 2'd1,
        OP_REVEAL   = 2'd2,
        OP_NEW_GAME = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_COUNT,
        S_PLAY,
        S_LOST,
        S_WON
    } state_e;

    localparam int FLAG_B    = 4;
    localparam int TIERRA_B  = 5;
    localparam int DESBLOQ_B = 6;
    localparam int BLOQ_B    = 7;
    localparam int MINE_B    = 8;

    localparam logic [8:0] CELL_COVERED = 9'h080;

endpackage

// File: rtl/board_state_writer_neighbor_counter.sv
// rtl/board_state_writer_neighbor_counter.sv - combinational mine count of the 8 in-bounds neighbours
module neighbor_counter #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  logic [ROWS*COLS-1:0]         i_mines,
    input  logic [$clog2(ROWS*COLS)-1:0] i_idx,
    output logic [3:0]                   o_count
);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(ROWS*COLS);

    int            w_r;
    int            w_c;
    int            w_nr;
    int            w_nc;
    logic [IW-1:0] w_nidx;

    // Out-of-range neighbours are skipped, so edge cells never wrap to the far side.
    always_comb begin
        w_r     = int'(i_idx[IW-1:CW]);
        w_c     = int'(i_idx[CW-1:0]);
        w_nr    = 0;
        w_nc    = 0;
        w_nidx  = '0;
        o_count = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                w_nr   = w_r + dr;
                w_nc   = w_c + dc;
                w_nidx = IW'(w_nr * COLS + w_nc);
                if ((dr != 0 || dc != 0) && w_nr >= 0 && w_nr < ROWS && w_nc >= 0 && w_nc < COLS)
                    o_count = o_count + {3'b000, i_mines[w_nidx]};
            end
        end
    end

endmodule

// File: rtl/board_state_writer.sv
// rtl/board_state_writer.sv - Minesweeper board owner: commands, LFSR mine placement, neighbour counts
module board_state_writer
    import ms_board_pkg::*;
#(
    parameter int          ROWS  = 8,
    parameter int          COLS  = 8,
    parameter int          MINES = 10,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [$clog2(ROWS)-1:0]        cmd_row,
    input  logic [$clog2(COLS)-1:0]        cmd_col,
    input  logic [$clog2(ROWS)-1:0]        rd_row,
    input  logic [$clog2(COLS)-1:0]        rd_col,
    output logic [8:0]                     rd_state,
    output logic                           busy,
    output logic                           game_lost,
    output logic                           game_won,
    output logic [$clog2(ROWS*COLS):0]     flags_placed
);
    localparam int N    = ROWS * COLS;
    localparam int IW   = $clog2(N);
    localparam int CNTW = IW + 1;

    state_e          r_state;
    state_e          w_next_state;
    logic [15:0]     r_lfsr;
    logic [8:0]      r_cells [N];
    logic [CNTW-1:0] r_placed;
    logic [CNTW-1:0] r_revealed;
    logic [CNTW-1:0] r_flags;
    logic [IW-1:0]   r_idx;

    logic [IW-1:0]   w_cmd_idx;
    logic [IW-1:0]   w_place_idx;
    logic [N-1:0]    w_mines;
    logic [3:0]      w_nc;
    logic            w_accept;
    logic            w_new_game;
    logic            w_flag;
    logic            w_reveal;
    logic            w_place_hit;

    // Power-of-two dimensions make the row-major index a plain concatenation.
    assign w_cmd_idx   = {cmd_row, cmd_col};
    assign w_place_idx = r_lfsr[IW-1:0];
    assign rd_state    = r_cells[{rd_row, rd_col}];
    assign game_lost   = (r_state == S_LOST);
    assign game_won    = (r_state == S_WON);
    assign flags_placed = r_flags;

    always_comb begin
        w_mines = '0;
        for (int i = 0; i < N; i++) w_mines[i] = r_cells[i][MINE_B];
    end

    neighbor_counter #(.ROWS(ROWS), .COLS(COLS)) u_nc (
        .i_mines (w_mines),
        .i_idx   (r_idx),
        .o_count (w_nc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        w_new_game   = 1'b0;
        w_flag       = 1'b0;
        w_reveal     = 1'b0;
        w_place_hit  = 1'b0;
        case (r_state)
            S_PLACE: begin
                busy        = 1'b1;
                w_place_hit = ~r_cells[w_place_idx][MINE_B];
                if (w_place_hit && r_placed == CNTW'(MINES - 1)) w_next_state = S_COUNT;
            end
            S_COUNT: begin
                busy = 1'b1;
                if (r_idx == IW'(N - 1)) w_next_state = S_PLAY;
            end
            default: cmd_ready = 1'b1;
        endcase
        w_accept = cmd_valid && cmd_ready;
        if (w_accept) begin
            case (cmd_op_e'(cmd_op))
                OP_NEW_GAME: begin
                    w_new_game   = 1'b1;
                    w_next_state = S_PLACE;
                end
                OP_FLAG: w_flag = (r_state == S_PLAY) && r_cells[w_cmd_idx][BLOQ_B];
                OP_REVEAL: begin
                    if (r_state == S_PLAY && r_cells[w_cmd_idx][BLOQ_B] && !r_cells[w_cmd_idx][FLAG_B]) begin
                        w_reveal = 1'b1;
                        if (r_cells[w_cmd_idx][MINE_B])                 w_next_state = S_LOST;
                        else if (r_revealed == CNTW'(N - MINES - 1))    w_next_state = S_WON;
                    end
                end
                default: ;
            endcase
        end
    end

    // The LFSR free-runs in every state so the layout depends on when NEW_GAME lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr     <= SEED;
            r_placed   <= '0;
            r_revealed <= '0;
            r_flags    <= '0;
            r_idx      <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            if (w_new_game) begin
                r_placed   <= '0;
                r_revealed <= '0;
                r_flags    <= '0;
                r_idx      <= '0;
            end else begin
                if (w_place_hit)        r_placed <= r_placed + 1'b1;
                if (r_state == S_COUNT) r_idx    <= r_idx + 1'b1;
                if (w_flag)             r_flags  <= r_cells[w_cmd_idx][FLAG_B] ? r_flags - 1'b1 : r_flags + 1'b1;
                if (w_reveal && !r_cells[w_cmd_idx][MINE_B]) r_revealed <= r_revealed + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_cells[i] <= CELL_COVERED;
        end else if (w_new_game) begin
            for (int i = 0; i < N; i++) r_cells[i] <= CELL_COVERED;
        end else begin
            if (w_place_hit)        r_cells[w_place_idx][MINE_B] <= 1'b1;
            if (r_state == S_COUNT) r_cells[r_idx][3:0] <= w_nc;
            if (w_flag)             r_cells[w_cmd_idx][FLAG_B] <= ~r_cells[w_cmd_idx][FLAG_B];
            if (w_reveal) begin
                r_cells[w_cmd_idx][BLOQ_B] <= 1'b0;
                if (r_cells[w_cmd_idx][MINE_B]) r_cells[w_cmd_idx][TIERRA_B]  <= 1'b1;
                else                            r_cells[w_cmd_idx][DESBLOQ_B] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_state_writer.sv
// tb/tb_board_state_writer.sv - table-driven and sequence checks for board_state_writer
`timescale 1ns/10ps
module tb_board_state_writer;
    import ms_board_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [2:0] cmd_col;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic [8:0] rd_state;
    logic       busy;
    logic       game_lost;
    logic       game_won;
    logic [6:0] flags_placed;

    int errors = 0;
    int checks = 0;

    logic       mine_map [64];
    logic [3:0] exp_cnt  [64];
    int         mine_total;

    typedef struct {
        logic [1:0] op;
        int         row;
        int         col;
        logic [3:0] hi;
        int         flags;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;

    board_state_writer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_state     (rd_state),
        .busy         (busy),
        .game_lost    (game_lost),
        .game_won     (game_won),
        .flags_placed (flags_placed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input int idx, output logic [8:0] v);
        rd_row = 3'(idx / 8);
        rd_col = 3'(idx % 8);
        #0.05;
        v = rd_state;
    endtask

    task automatic cmd(input logic [1:0] op, input int r, input int c);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = 3'(r);
        cmd_col   = 3'(c);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic build_map();
        logic [8:0] v;
        int         rr;
        int         cc;
        mine_total = 0;
        for (int i = 0; i < 64; i++) begin
            rd(i, v);
            mine_map[i] = v[8];
            if (v[8]) mine_total++;
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                exp_cnt[r*8+c] = 4'd0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && mine_map[rr*8+cc])
                            exp_cnt[r*8+c] = exp_cnt[r*8+c] + 4'd1;
                    end
                end
            end
        end
    endtask

    function automatic logic [8:0] word(input int i, input logic [3:0] hi);
        return {mine_map[i], hi, exp_cnt[i]};
    endfunction

    task automatic check_fresh_board(input string name);
        logic [8:0] v;
        int         bad;
        build_map();
        chk({name, "_mine_total"}, mine_total, 10);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd(i, v);
            if (v !== word(i, 4'b1000)) begin
                bad++;
                $display("FAIL %s_cell%0d: got %0h expected %0h", name, i, v, word(i, 4'b1000));
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    initial begin
        logic [8:0] v;
        int         bad;
        int         k;
        int         mine_i;
        int         safe_i;

        vt[0] = '{OP_FLAG,   2, 3, 4'b1001, 1};
        vt[1] = '{OP_REVEAL, 2, 3, 4'b1001, 1};
        vt[2] = '{OP_FLAG,   0, 0, 4'b1001, 2};
        vt[3] = '{OP_NOP,    0, 0, 4'b1001, 2};
        vt[4] = '{OP_FLAG,   0, 0, 4'b1000, 1};
        vt[5] = '{OP_FLAG,   2, 3, 4'b1000, 0};
        vt[6] = '{OP_FLAG,   7, 7, 4'b1001, 1};
        vt[7] = '{OP_FLAG,   7, 7, 4'b1000, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_row = '0; cmd_col = '0;
        rd_row = '0; rd_col = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_lost", game_lost, 0);
        chk("reset_won", game_won, 0);
        chk("reset_flags", flags_placed, 0);
        rd(27, v);
        chk("reset_cell27", v, 9'h080);

        cmd(OP_FLAG, 1, 1);
        rd(9, v);
        chk("idle_flag_ignored", v, 9'h080);

        cmd(OP_NEW_GAME, 0, 0);
        chk("place_busy", busy, 1);
        chk("place_not_ready", cmd_ready, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #0.1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", cmd_ready, 1);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            rd(i, v);
            if (v !== 9'h080) bad++;
        end
        chk("async_rst_cells_bad", bad, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        cmd(OP_NEW_GAME, 0, 0);
        rd(0, v);
        chk("newgame_clear_cell0", v, 9'h080);
        wait_idle("game1_busy_timeout");
        chk("game1_ready", cmd_ready, 1);
        check_fresh_board("game1");

        for (int i = 0; i < 8; i++) begin
            cmd(vt[i].op, vt[i].row, vt[i].col);
            rd(vt[i].row * 8 + vt[i].col, v);
            chk($sformatf("vec%0d_cell", i), v, word(vt[i].row * 8 + vt[i].col, vt[i].hi));
            chk($sformatf("vec%0d_flags", i), flags_placed, vt[i].flags);
        end

        k = 0;
        mine_i = 0;
        for (int i = 0; i < 64; i++) begin
            if (mine_map[i]) begin
                mine_i = i;
            end else begin
                cmd(OP_REVEAL, i / 8, i % 8);
                k++;
                if (k == 1) begin
                    rd(i, v);
                    chk("reveal_safe_cell", v, word(i, 4'b0100));
                end
                if (k == 53) chk("won_before_last", game_won, 0);
                if (k == 54) chk("won_after_last", game_won, 1);
            end
        end
        chk("won_lost_low", game_lost, 0);
        chk("won_ready", cmd_ready, 1);
        cmd(OP_REVEAL, mine_i / 8, mine_i % 8);
        rd(mine_i, v);
        chk("won_reveal_ignored", v, word(mine_i, 4'b1000));
        chk("won_still_lost_low", game_lost, 0);

        cmd(OP_NEW_GAME, 0, 0);
        chk("game2_won_clear", game_won, 0);
        wait_idle("game2_busy_timeout");
        check_fresh_board("game2");
        mine_i = -1;
        safe_i = -1;
        for (int i = 0; i < 64; i++) begin
            if (mine_map[i] && mine_i < 0) mine_i = i;
            if (!mine_map[i] && safe_i < 0) safe_i = i;
        end
        cmd(OP_REVEAL, mine_i / 8, mine_i % 8);
        rd(mine_i, v);
        chk("lost_mine_cell", v, word(mine_i, 4'b0010));
        chk("lost_flag", game_lost, 1);
        chk("lost_won_low", game_won, 0);
        cmd(OP_REVEAL, safe_i / 8, safe_i % 8);
        rd(safe_i, v);
        chk("lost_reveal_ignored", v, word(safe_i, 4'b1000));
        cmd(OP_FLAG, safe_i / 8, safe_i % 8);
        rd(safe_i, v);
        chk("lost_flag_ignored", v, word(safe_i, 4'b1000));
        chk("lost_flags_zero", flags_placed, 0);

        cmd(OP_NEW_GAME, 0, 0);
        chk("game3_lost_clear", game_lost, 0);
        repeat (40) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = OP_NEW_GAME;
        bad = 0;
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!busy) begin
                k = 1;
                break;
            end
            if (cmd_ready) bad++;
        end
        chk("hold_busy_timeout", k, 1);
        chk("hold_ready_while_busy", bad, 0);
        chk("hold_first_play_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        chk("hold_accepted_restart", busy, 1);
        wait_idle("game4_busy_timeout");
        check_fresh_board("game4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
